bram_512x8_sdp: RTL and testbench
=================================

Name: bram_512x8_sdp

Overview:
- Simple dual-port block RAM: 512 words x 8 bits, one write port and one read port, single clock domain.
- Targets one iCE40 SB_RAM40_4K in 512x8 mode; also simulates behaviourally.
- Used as a general scratch/buffer memory by surrounding pipeline blocks.

Parameters:
- ADDR_W, 9, address width in bits; depth = 2**ADDR_W.
- DATA_W, 8, word width in bits.

Ports:
- clock  input  1  sole clock; all sequential logic uses the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- raddr  input  9  read address, sampled on the rising clock edge.
- rdata  output 8  registered read data.
- waddr  input  9  write address, sampled on the rising clock edge.
- wdata  input  8  write data.
- wren   input  1  write enable, active high.

Behaviour:
- Storage: 512 x 8 array, addresses 0..511; every address is in range, so there is no wrap or clamp logic.
- Initial contents at configuration/simulation start are all zeros. rst_n does NOT clear the array.
- Write: on a rising edge with wren=1, mem[waddr] <= wdata. With wren=0 the array is unchanged. One write per cycle.
- Read: on every rising edge, rdata <= mem[raddr]. There is no read enable; the read is always active.
- Read latency is 1 cycle: an address applied before edge N appears on rdata after edge N and holds until edge N+1.
- Read-during-write to the same address on the same edge is read-first: rdata returns the old contents, and the new value is visible from the next read.
- Read and write to different addresses on the same edge are fully independent.
- Reset: while rst_n=0, rdata is forced to 8'h00 asynchronously. Writes are ignored while rst_n=0.
- After rst_n deasserts, the first edge loads rdata normally.
- X on wren while not in reset is not supported; the verification engineer flags it with an assertion.

Decomposition:
- Shared package bram_pkg holds:
  - BRAM512_ADDR_W = 9
  - BRAM512_DATA_W = 8
  - typedef bram512_addr_t (logic[8:0])
  - typedef bram512_data_t (logic[7:0])
- Sub-module bram_core_sdp holds the bare array plus the registered read, with no reset.
  - The top level wraps it and adds the rst_n output-register clear and the write gating.
  - This keeps the array inferable as SB_RAM40_4K.

Test Plan:
- Fill/readback: write mem[i] = (i+70) mod 256 for i = 0..511 (one write per cycle, raddr=0), then read 0..511 sequentially.
  - Expected: rdata after each read edge = (i+70)&8'hFF, e.g. addr0 = 8'h46, addr186 = 8'h00, addr511 = 8'h45.
- Latency: write 8'hA5 to addr 3, then apply raddr=3.
  - Before the edge, rdata holds the previous value.
  - After one rising edge, rdata = 8'hA5.
- Read-during-write: mem[7] = 8'h11; same edge: waddr=7, wdata=8'h22, wren=1, raddr=7.
  - rdata = 8'h11 after that edge.
  - rdata = 8'h22 after the next edge.
- Write gating: mem[9] = 8'h33; drive waddr=9, wdata=8'hFF, wren=0 for several cycles.
  - Reading addr 9 returns 8'h33.
- Reset: with rdata = 8'h46, assert rst_n=0 mid-cycle.
  - rdata becomes 8'h00 immediately, without waiting for an edge.
  - Attempted write during reset has no effect.
  - After release, reading previously written addresses returns the pre-reset contents.
- Boundary addresses: write addr 0 = 8'h01 and addr 511 = 8'hFE.
  - Reads return 8'h01 and 8'hFE; neighbours 1 and 510 are unchanged.

Source files
------------

// File: rtl/bram_pkg.sv
// Shared types and sizes for the 512x8 simple dual-port block RAM.
package bram_pkg;

  localparam int BRAM512_ADDR_W = 9;
  localparam int BRAM512_DATA_W = 8;
  localparam int BRAM512_DEPTH  = 2 ** BRAM512_ADDR_W;

  typedef logic [BRAM512_ADDR_W-1:0] bram512_addr_t;
  typedef logic [BRAM512_DATA_W-1:0] bram512_data_t;

endpackage : bram_pkg

// File: rtl/bram_512x8_sdp_if.sv
// Write/read bus of the 512x8 simple dual-port RAM.
// The client (master) drives addresses and write data; the RAM (slave) returns rdata.
interface bram_512x8_sdp_if;
  import bram_pkg::*;

  bram512_addr_t raddr;
  bram512_data_t rdata;
  bram512_addr_t waddr;
  bram512_data_t wdata;
  logic          wren;

  modport master (
    output raddr,
    output waddr,
    output wdata,
    output wren,
    input  rdata
  );

  modport slave (
    input  raddr,
    input  waddr,
    input  wdata,
    input  wren,
    output rdata
  );

endinterface : bram_512x8_sdp_if

// File: rtl/bram_core_sdp.sv
// Bare 512x8 array with one write port and a registered, always-active read port.
// Kept free of any reset so synthesis can map it onto a single SB_RAM40_4K.
module bram_core_sdp
  import bram_pkg::*;
(
  input  logic          clk_i,
  input  logic          we_i,
  input  bram512_addr_t waddr_i,
  input  bram512_data_t wdata_i,
  input  bram512_addr_t raddr_i,
  output bram512_data_t rdata_o
);

  // NOTE: the storage array has no reset; clearing it would turn it into flops
  // and block mapping onto the block RAM primitive.
  bram512_data_t mem_q [BRAM512_DEPTH];
  bram512_data_t rdata_q;

  // Write on enable and register the read every cycle; the read samples the
  // array before this edge's write lands, giving read-first behaviour.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule : bram_core_sdp

// File: rtl/bram_512x8_sdp.sv
// 512x8 simple dual-port RAM top: wraps the bare core, blocks writes during
// reset and holds the visible read data at zero until the first edge after reset.
module bram_512x8_sdp
  import bram_pkg::*;
(
  input  logic                     clock,
  input  logic                     rst_n,
  bram_512x8_sdp_if.slave          bus
);

  logic          we;
  bram512_data_t core_rdata;
  logic          rd_valid_q;

  // Writes only take effect outside reset.
  assign we = bus.wren & rst_n;

  bram_core_sdp u_core (
    .clk_i   (clock),
    .we_i    (we),
    .waddr_i (bus.waddr),
    .wdata_i (bus.wdata),
    .raddr_i (bus.raddr),
    .rdata_o (core_rdata)
  );

  // Tracks whether the core's output register has been loaded since reset; it
  // clears at once on rst_n and sets on the first edge after release.
  // NOTE: sequential state uses non-blocking assignments with an async
  // active-low clear in the sensitivity list.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b1;
    end
  end

  // Output register appears cleared while in reset and until its first reload.
  assign bus.rdata = rd_valid_q ? core_rdata : '0;

endmodule : bram_512x8_sdp

// File: tb/tb_bram_512x8_sdp.sv
// Self-checking bench for bram_512x8_sdp: fill/readback, reset behaviour,
// then a directed vector table covering latency, read-during-write, write
// gating and the boundary addresses.
module tb_bram_512x8_sdp;
  import bram_pkg::*;

  logic clock;
  logic rst_n;
  int   errors;
  int   checks;

  bram_512x8_sdp_if bus ();

  bram_512x8_sdp dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Unknown write enable outside reset is not a supported input.
  always @(posedge clock) begin
    if (rst_n === 1'b1 && $isunknown(bus.wren)) begin
      $error("wren is unknown outside reset");
    end
  end

  typedef struct {
    string         name;
    bram512_addr_t waddr;
    bram512_data_t wdata;
    logic          wren;
    bram512_addr_t raddr;
    bram512_data_t exp_rdata;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input bram512_data_t act, input bram512_data_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: rdata=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, take the edge, then settle before sampling.
  task automatic step(input bram512_addr_t wa, input bram512_data_t wd, input logic we,
                      input bram512_addr_t ra);
    bus.waddr = wa;
    bus.wdata = wd;
    bus.wren  = we;
    bus.raddr = ra;
    @(posedge clock);
    #1;
  endtask

  function automatic bram512_data_t fill_val(input int i);
    return bram512_data_t'((i + 70) % 256);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    errors = 0;
    checks = 0;

    vecs[0]  = '{"rdw_setup",   9'd7,   8'h11, 1'b1, 9'd9,   8'h4F};
    vecs[1]  = '{"rdw_old",     9'd7,   8'h22, 1'b1, 9'd7,   8'h11};
    vecs[2]  = '{"rdw_new",     9'd0,   8'h00, 1'b0, 9'd7,   8'h22};
    vecs[3]  = '{"gate_setup",  9'd9,   8'h33, 1'b1, 9'd0,   8'h46};
    vecs[4]  = '{"gate_hold0",  9'd9,   8'hFF, 1'b0, 9'd9,   8'h33};
    vecs[5]  = '{"gate_hold1",  9'd9,   8'hFF, 1'b0, 9'd9,   8'h33};
    vecs[6]  = '{"gate_hold2",  9'd9,   8'hFF, 1'b0, 9'd9,   8'h33};
    vecs[7]  = '{"bnd_w0",      9'd0,   8'h01, 1'b1, 9'd1,   8'h47};
    vecs[8]  = '{"bnd_w511",    9'd511, 8'hFE, 1'b1, 9'd510, 8'h44};
    vecs[9]  = '{"bnd_r0",      9'd0,   8'h00, 1'b0, 9'd0,   8'h01};
    vecs[10] = '{"bnd_r511",    9'd0,   8'h00, 1'b0, 9'd511, 8'hFE};
    vecs[11] = '{"bnd_r1",      9'd0,   8'h00, 1'b0, 9'd1,   8'h47};
    vecs[12] = '{"bnd_r510",    9'd0,   8'h00, 1'b0, 9'd510, 8'h44};
    vecs[13] = '{"indep_wr",    9'd5,   8'hAB, 1'b1, 9'd6,   8'h4C};
    vecs[14] = '{"indep_rd",    9'd0,   8'h00, 1'b0, 9'd5,   8'hAB};

    // Reset at start.
    rst_n     = 1'b0;
    bus.waddr = '0;
    bus.wdata = '0;
    bus.wren  = 1'b0;
    bus.raddr = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_init", bus.rdata, 8'h00);
    rst_n = 1'b1;

    // Fill every address, then read it all back.
    for (int i = 0; i < BRAM512_DEPTH; i++) begin
      step(bram512_addr_t'(i), fill_val(i), 1'b1, 9'd0);
    end
    for (int i = 0; i < BRAM512_DEPTH; i++) begin
      step(9'd0, 8'h00, 1'b0, bram512_addr_t'(i));
      check($sformatf("fill_rd[%0d]", i), bus.rdata, fill_val(i));
    end

    // Reset mid-cycle with rdata = 8'h46: clears immediately, blocks writes.
    step(9'd0, 8'h00, 1'b0, 9'd0);
    check("pre_reset", bus.rdata, 8'h46);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async", bus.rdata, 8'h00);
    step(9'd0, 8'hEE, 1'b1, 9'd0);
    check("reset_hold0", bus.rdata, 8'h00);
    step(9'd0, 8'hEE, 1'b1, 9'd0);
    check("reset_hold1", bus.rdata, 8'h00);
    bus.wren = 1'b0;
    #1;
    rst_n = 1'b1;
    step(9'd0, 8'h00, 1'b0, 9'd0);
    check("post_reset_a0", bus.rdata, 8'h46);
    step(9'd0, 8'h00, 1'b0, 9'd200);
    check("post_reset_a200", bus.rdata, fill_val(200));

    // Latency: write A5 to addr 3, then observe it one edge after raddr=3.
    step(9'd3, 8'hA5, 1'b1, 9'd0);
    check("lat_prev", bus.rdata, 8'h46);
    bus.wren  = 1'b0;
    bus.raddr = 9'd3;
    #2;
    check("lat_before_edge", bus.rdata, 8'h46);
    @(posedge clock);
    #1;
    check("lat_after_edge", bus.rdata, 8'hA5);

    // Directed vector table.
    for (int v = 0; v < 15; v++) begin
      step(vecs[v].waddr, vecs[v].wdata, vecs[v].wren, vecs[v].raddr);
      check(vecs[v].name, bus.rdata, vecs[v].exp_rdata);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_bram_512x8_sdp
